// File: rtl/efuse_pkg.sv
// efuse_pkg: shared definitions for the eFuse serial-bus readback monitor.
//   EFUSE_NBITS / EFUSE_CNTW : default frame width and counter width
//   state_t                  : monitor FSM encoding
//   FRAME_PROG / FRAME_READ  : SCLK level at the CSB fall that selects the frame type
package efuse_pkg;
   localparam int EFUSE_NBITS = 32;
   localparam int EFUSE_CNTW  = 6;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROG = 2'd1,
      READ = 2'd2
   } state_t;
   localparam logic FRAME_PROG = 1'b0;
   localparam logic FRAME_READ = 1'b1;
endpackage

// File: rtl/efuse_readback_mon.sv
// efuse_readback_mon: passive monitor of the eFuse serial bus; checks read frames
// against the programmed word and reports SCLK/ones counts of program frames.
//   clk_1M, rst            : clock, synchronous active-high reset
//   CSB, PGM, SCLK, DOUT   : monitored eFuse bus lines (same clock domain)
//   expected               : word the sequencer programmed, sampled at read-frame end
//   fuse_data, pass        : last read-back word and its match result
//   data_valid, prog_done  : one-cycle frame-complete pulses
//   frame_err              : last completed frame had a bit count != NBITS
//   prog_ones              : count of PGM=1 SCLK rises in the last program frame
//   busy                   : a frame is open
module efuse_readback_mon
   import efuse_pkg::*;
#(
   parameter int NBITS = EFUSE_NBITS,
   parameter int CNTW  = EFUSE_CNTW
) (
   input  logic             clk_1M,
   input  logic             rst,
   input  logic             CSB,
   input  logic             PGM,
   input  logic             SCLK,
   input  logic             DOUT,
   input  logic [NBITS-1:0] expected,
   output logic [NBITS-1:0] fuse_data,
   output logic             data_valid,
   output logic             pass,
   output logic             frame_err,
   output logic             prog_done,
   output logic [CNTW-1:0]  prog_ones,
   output logic             busy
);
   localparam logic [CNTW-1:0] L_N   = CNTW'(NBITS);
   localparam logic [CNTW-1:0] L_SAT = CNTW'(NBITS + 1);

   state_t             r_state;
   logic               r_csb_q;
   logic               r_sclk_q;
   logic [NBITS-1:0]   r_shift;
   logic [CNTW-1:0]    r_bit_cnt;
   logic [CNTW-1:0]    r_ones_cnt;
   logic               w_csb_fall;
   logic               w_csb_rise;
   logic               w_sclk_rise;

   // Reset values csb_q=0 / sclk_q=1 suppress edges from lines held across reset.
   assign w_csb_fall  = r_csb_q & ~CSB;
   assign w_csb_rise  = ~r_csb_q & CSB;
   assign w_sclk_rise = ~r_sclk_q & SCLK;
   assign busy        = r_state != IDLE;

   always_ff @(posedge clk_1M) begin
      if (rst) begin
         r_state    <= IDLE;
         r_csb_q    <= 1'b0;
         r_sclk_q   <= 1'b1;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_ones_cnt <= '0;
         fuse_data  <= '0;
         data_valid <= 1'b0;
         pass       <= 1'b0;
         frame_err  <= 1'b0;
         prog_done  <= 1'b0;
         prog_ones  <= '0;
      end else begin
         r_csb_q    <= CSB;
         r_sclk_q   <= SCLK;
         data_valid <= 1'b0;
         prog_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_csb_fall) begin
                  r_state    <= (SCLK == FRAME_READ) ? READ : PROG;
                  r_bit_cnt  <= '0;
                  r_ones_cnt <= '0;
                  if (SCLK == FRAME_READ) r_shift <= '0;
               end
            end
            READ: begin
               // A CSB rise closes the frame even if SCLK rises in the same cycle.
               if (w_csb_rise) begin
                  r_state    <= IDLE;
                  fuse_data  <= r_shift;
                  pass       <= (r_bit_cnt == L_N) && (r_shift == expected);
                  frame_err  <= r_bit_cnt != L_N;
                  data_valid <= 1'b1;
               end else if (w_sclk_rise && !CSB) begin
                  for (int i = 0; i < NBITS; i++)
                     if (r_bit_cnt == CNTW'(i)) r_shift[i] <= DOUT;
                  if (r_bit_cnt != L_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            PROG: begin
               if (w_csb_rise) begin
                  r_state   <= IDLE;
                  prog_ones <= r_ones_cnt;
                  frame_err <= r_bit_cnt != L_N;
                  prog_done <= 1'b1;
               end else if (w_sclk_rise && !CSB) begin
                  if (r_bit_cnt != L_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (PGM && r_ones_cnt != L_SAT) r_ones_cnt <= r_ones_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_efuse_readback_mon.sv
// tb_efuse_readback_mon: directed self-checking bench for efuse_readback_mon.
module tb_efuse_readback_mon;
   logic        clk_1M = 1'b0;
   logic        rst = 1'b1;
   logic        CSB = 1'b1;
   logic        PGM = 1'b0;
   logic        SCLK = 1'b1;
   logic        DOUT = 1'b0;
   logic [31:0] expected = '0;
   logic [31:0] fuse_data;
   logic        data_valid;
   logic        pass;
   logic        frame_err;
   logic        prog_done;
   logic [5:0]  prog_ones;
   logic        busy;
   int          tests = 0;
   int          fails = 0;
   int          dv_cnt = 0;
   int          pd_cnt = 0;

   efuse_readback_mon #(.NBITS(32), .CNTW(6)) dut (
      .clk_1M(clk_1M), .rst(rst), .CSB(CSB), .PGM(PGM), .SCLK(SCLK), .DOUT(DOUT),
      .expected(expected), .fuse_data(fuse_data), .data_valid(data_valid), .pass(pass),
      .frame_err(frame_err), .prog_done(prog_done), .prog_ones(prog_ones), .busy(busy)
   );

   always #5 clk_1M = ~clk_1M;

   always @(negedge clk_1M) begin
      if (data_valid) dv_cnt++;
      if (prog_done) pd_cnt++;
   end

   task automatic tick();
      @(posedge clk_1M);
      #1;
   endtask

   task automatic pulse(input logic b);
      SCLK = 1'b0;
      DOUT = b;
      PGM  = b;
      repeat (5) tick();
      SCLK = 1'b1;
      tick();
   endtask

   // Drives one frame; on return the frame-end report is visible on the outputs.
   // merge=1 raises CSB together with the last SCLK rise.
   task automatic frame(input logic rd, input logic [31:0] dat, input int n, input logic merge);
      CSB = 1'b1;
      SCLK = rd;
      tick();
      tick();
      CSB = 1'b0;
      tick();
      for (int i = 0; i < n; i++) begin
         SCLK = 1'b0;
         DOUT = dat[i];
         PGM  = dat[i];
         repeat (5) tick();
         SCLK = 1'b1;
         if (merge && i == n - 1) CSB = 1'b1;
         tick();
      end
      if (!merge) begin
         SCLK = 1'b0;
         tick();
         CSB = 1'b1;
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      tests++; if (fuse_data !== 32'h0) begin fails++; $display("FAIL reset_fuse_data got %h exp 0", fuse_data); end
      tests++; if ({data_valid, pass, frame_err, prog_done} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {data_valid, pass, frame_err, prog_done}); end
      tests++; if (prog_ones !== 6'd0) begin fails++; $display("FAIL reset_prog_ones got %0d exp 0", prog_ones); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
   endtask

   task automatic test_read_ok();
      int dv0;
      dv0 = dv_cnt;
      expected = 32'hA5A5_0F0F;
      frame(1'b1, 32'hA5A5_0F0F, 32, 1'b0);
      tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL rd_valid got %b exp 1", data_valid); end
      tests++; if (fuse_data !== 32'hA5A5_0F0F) begin fails++; $display("FAIL rd_data got %h exp a5a50f0f", fuse_data); end
      tests++; if (pass !== 1'b1) begin fails++; $display("FAIL rd_pass got %b exp 1", pass); end
      tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rd_err got %b exp 0", frame_err); end
      tick();
      tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_pulse got %b exp 0", data_valid); end
      tests++; if (dv_cnt - dv0 !== 1) begin fails++; $display("FAIL rd_valid_count got %0d exp 1", dv_cnt - dv0); end
   endtask

   task automatic test_read_bad_bit();
      expected = 32'hA5A5_0F0F;
      frame(1'b1, 32'hA5A5_0F07, 32, 1'b0);
      tests++; if (fuse_data !== 32'hA5A5_0F07) begin fails++; $display("FAIL bad_data got %h exp a5a50f07", fuse_data); end
      tests++; if (pass !== 1'b0) begin fails++; $display("FAIL bad_pass got %b exp 0", pass); end
      tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL bad_err got %b exp 0", frame_err); end
      tick();
   endtask

   task automatic test_read_short();
      expected = 32'hA5A5_0F0F;
      frame(1'b1, 32'hA5A5_0F0F, 31, 1'b0);
      tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL short_valid got %b exp 1", data_valid); end
      tests++; if (fuse_data !== 32'h25A5_0F0F) begin fails++; $display("FAIL short_data got %h exp 25a50f0f", fuse_data); end
      tests++; if (pass !== 1'b0) begin fails++; $display("FAIL short_pass got %b exp 0", pass); end
      tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL short_err got %b exp 1", frame_err); end
      tick();
   endtask

   task automatic test_prog();
      int dv0, pd0;
      dv0 = dv_cnt;
      pd0 = pd_cnt;
      frame(1'b0, 32'h0000_00FF, 32, 1'b0);
      tests++; if (prog_done !== 1'b1) begin fails++; $display("FAIL prog_done got %b exp 1", prog_done); end
      tests++; if (prog_ones !== 6'd8) begin fails++; $display("FAIL prog_ones got %0d exp 8", prog_ones); end
      tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL prog_err got %b exp 0", frame_err); end
      tests++; if (fuse_data !== 32'h25A5_0F0F) begin fails++; $display("FAIL prog_fuse_hold got %h exp 25a50f0f", fuse_data); end
      tick();
      tests++; if (pd_cnt - pd0 !== 1) begin fails++; $display("FAIL prog_done_count got %0d exp 1", pd_cnt - pd0); end
      tests++; if (dv_cnt !== dv0) begin fails++; $display("FAIL prog_no_valid got %0d exp %0d", dv_cnt, dv0); end
   endtask

   task automatic test_reset_mid_frame();
      int dv0;
      CSB = 1'b1;
      SCLK = 1'b1;
      tick();
      tick();
      CSB = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) pulse(1'b1);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %b exp 1", busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if (prog_ones !== 6'd0 || fuse_data !== 32'h0) begin fails++; $display("FAIL mid_rst_regs got %0d/%h exp 0/0", prog_ones, fuse_data); end
      tests++; if ({busy, data_valid, pass, frame_err, prog_done} !== 5'b0) begin fails++; $display("FAIL mid_rst_flags got %b exp 00000", {busy, data_valid, pass, frame_err, prog_done}); end
      dv0 = dv_cnt;
      for (int i = 0; i < 5; i++) pulse(1'b1);
      SCLK = 1'b0;
      tick();
      CSB = 1'b1;
      tick();
      tick();
      tests++; if (dv_cnt !== dv0) begin fails++; $display("FAIL mid_no_report got %0d exp %0d", dv_cnt, dv0); end
      expected = 32'h1234_5678;
      frame(1'b1, 32'h1234_5678, 32, 1'b0);
      tests++; if (pass !== 1'b1 || fuse_data !== 32'h1234_5678) begin fails++; $display("FAIL after_rst got %b/%h exp 1/12345678", pass, fuse_data); end
      tick();
   endtask

   task automatic test_back_to_back_edge();
      expected = 32'hA5A5_0F0F;
      frame(1'b1, 32'hA5A5_0F0F, 32, 1'b1);
      tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL merge_valid got %b exp 1", data_valid); end
      tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL merge_err got %b exp 1", frame_err); end
      tests++; if (pass !== 1'b0) begin fails++; $display("FAIL merge_pass got %b exp 0", pass); end
      tests++; if (fuse_data !== 32'h25A5_0F0F) begin fails++; $display("FAIL merge_data got %h exp 25a50f0f", fuse_data); end
      tick();
   endtask

   initial begin
      test_reset();
      test_read_ok();
      test_read_bad_bit();
      test_read_short();
      test_prog();
      test_reset_mid_frame();
      test_back_to_back_edge();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
